perip_bus_master: RTL and testbench

//  Initiator for the peripheral register bus (write/byte-enable/addr/wdata/rdata) that GPIO-style responders implement.

---
 rtl/perip_bus_master.sv | 194 +++++++++++++++++++
 tb/tb_perip_bus_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/perip_bus_master.sv
// perip_bus_master: CPU load/store to peripheral register bus initiator.
// Turns one valid/ready request into one or two word-aligned bus beats with
// lane byte-enables, then returns a single-cycle response carrying the
// aligned, size-truncated and sign/zero-extended load data.
// Optional build macro: MISALIGN_SPLIT_EN. When defined, word-crossing
// accesses are split into two beats. When undefined, they are rejected
// with rsp_err_o and never reach the bus.
module perip_bus_master #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              bus_write_o,
  output logic [3:0]        bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  // Lane enables over two consecutive words: size mask shifted by offset.
  function automatic logic [7:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'b0000_0001;
      2'd1:    m = 8'b0000_0011;
      default: m = 8'b0000_1111;
    endcase
    return m << off;
  endfunction

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-3:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0]  lane_en;
  logic [4:0]  sh0;
  logic [4:0]  sh1;
  logic        req_bad;
  logic [31:0] rdata_ext;
  logic        unused_ok;

  assign lane_en = lane_enables(size_q, off_q);
  assign sh0     = {off_q, 3'b000};
  // 32 - 8*off, modulo 32; only meaningful when off != 0 (a crossing access).
  assign sh1     = 5'd0 - sh0;

`ifdef MISALIGN_SPLIT_EN
  logic cross;
  assign cross     = |lane_en[7:4];
  assign req_bad   = (req_size_i == 2'd3);
  assign unused_ok = ^req_addr_i[31:ADDR_W];
`else
  logic [7:0] req_en;
  assign req_en    = lane_enables(req_size_i, req_addr_i[1:0]);
  assign req_bad   = (req_size_i == 2'd3) || (|req_en[7:4]);
  assign unused_ok = ^{req_addr_i[31:ADDR_W], lane_en[7:4]};
`endif

  // Truncate the assembled load data to the access size, then extend.
  always_comb begin
    case (size_q)
      2'd0:    rdata_ext = {{24{signed_q & rdata_q[7]}},  rdata_q[7:0]};
      2'd1:    rdata_ext = {{16{signed_q & rdata_q[15]}}, rdata_q[15:0]};
      default: rdata_ext = rdata_q;
    endcase
  end

  // State and request/data registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      off_q    <= 2'd0;
      word_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      off_q    <= off_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state: accept in IDLE, capture read lanes during beats.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    off_d    = off_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          write_d  = req_write_i;
          size_d   = req_size_i;
          signed_d = req_signed_i;
          off_d    = req_addr_i[1:0];
          word_d   = req_addr_i[ADDR_W-1:2];
          wdata_d  = req_wdata_i;
          rdata_d  = '0;
          err_d    = req_bad;
          state_d  = req_bad ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        rdata_d = bus_rdata_i >> sh0;
`ifdef MISALIGN_SPLIT_EN
        state_d = cross ? BEAT1 : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      BEAT1: begin
        // Upper bytes come from the next word; lower bytes keep BEAT0 data.
        rdata_d = (rdata_q & ~(32'hFFFF_FFFF << sh1)) |
                  ((bus_rdata_i << sh1) & (32'hFFFF_FFFF << sh1));
        state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    bus_write_o = 1'b0;
    bus_be_o    = '0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    case (state_q)
      BEAT0: begin
        bus_write_o = write_q;
        bus_be_o    = lane_en[3:0];
        bus_addr_o  = {word_q, 2'b00};
        bus_wdata_o = wdata_q << sh0;
      end
`ifdef MISALIGN_SPLIT_EN
      BEAT1: begin
        bus_write_o = write_q;
        bus_be_o    = lane_en[7:4];
        bus_addr_o  = {word_q + (ADDR_W-2)'(1), 2'b00};
        bus_wdata_o = wdata_q >> sh1;
      end
`endif
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (write_q || err_q) ? 32'd0 : rdata_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_perip_bus_master.sv
// Bench for perip_bus_master. Expected responses are queued at accept time
// and matched by an independent monitor when rsp_valid_o pulses; bus beats
// are compared directly in their cycle. Works with or without
// MISALIGN_SPLIT_EN; crossing vectors expect errors when it is undefined.
module tb_perip_bus_master;

  localparam int ADDR_W = 6;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic              req_write_i = 1'b0;
  logic [31:0]       req_addr_i = '0;
  logic [1:0]        req_size_i = '0;
  logic              req_signed_i = 1'b0;
  logic [31:0]       req_wdata_i = '0;
  logic              rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              bus_write_o;
  logic [3:0]        bus_be_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [31:0]       bus_wdata_o;
  logic [31:0]       bus_rdata_i;

  logic [31:0] rd_tab [16];
  assign bus_rdata_i = rd_tab[bus_addr_o[5:2]];

  perip_bus_master #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .bus_write_o(bus_write_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_beat(input string tag, input logic wr, input logic [3:0] be,
                            input logic [5:0] addr, input logic [31:0] wd);
    check({tag, "_write"}, 32'(bus_write_o), 32'(wr));
    check({tag, "_be"},    32'(bus_be_o),    32'(be));
    check({tag, "_addr"},  32'(bus_addr_o),  32'(addr));
    check({tag, "_wdata"}, bus_wdata_o,      wd);
  endtask

  // Call at a negedge; returns at the negedge of the cycle after accept.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input bit expect_rsp);
    int waited;
    exp_t e;
    req_write_i  = wr;
    req_addr_i   = addr;
    req_size_i   = size;
    req_signed_i = sgn;
    req_wdata_i  = wd;
    req_valid_i  = 1'b1;
    waited = 0;
    while (!req_ready_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    if (!req_ready_o) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    last_acc = cyc;
    if (expect_rsp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = cyc + lat;
      sb_q.push_back(e);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Response monitor: pops one expectation per rsp_valid_o pulse.
  always @(negedge clk_i) begin
    if (rsp_valid_o) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata_o, e.rdata);
        check("rsp_err",   32'(rsp_err_o), 32'(e.err));
        check("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    int a1;
    for (int i = 0; i < 16; i++) rd_tab[i] = 32'd0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_be", 32'(bus_be_o), 32'd0);
    check("rst_addr", 32'(bus_addr_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1: aligned word store
    issue(1'b1, 32'h04, 2'd2, 1'b0, 32'hA5A5_1234, 32'd0, 1'b0, 2, 1'b1);
    check_beat("sw", 1'b1, 4'b1111, 6'h04, 32'hA5A5_1234);
    check("sw_ready_beat", 32'(req_ready_o), 32'd0);
    repeat (3) @(negedge clk_i);

    // 2: byte load, signed and unsigned
    rd_tab[0] = 32'h0000_8000;
    issue(1'b0, 32'h01, 2'd0, 1'b1, 32'd0, 32'hFFFF_FF80, 1'b0, 2, 1'b1);
    check_beat("lb", 1'b0, 4'b0010, 6'h00, 32'd0);
    issue(1'b0, 32'h01, 2'd0, 1'b0, 32'd0, 32'h0000_0080, 1'b0, 2, 1'b1);
    check_beat("lbu", 1'b0, 4'b0010, 6'h00, 32'd0);
    repeat (3) @(negedge clk_i);

    // Upper request address bits are ignored
    rd_tab[0] = 32'h5A7F_3C00;
    issue(1'b0, 32'h1234_0042, 2'd0, 1'b1, 32'd0, 32'h0000_007F, 1'b0, 2, 1'b1);
    check_beat("lb_hi", 1'b0, 4'b0100, 6'h00, 32'd0);
    repeat (3) @(negedge clk_i);

    // 3: unsigned half crossing a word
    rd_tab[0] = 32'h1100_0000;
    rd_tab[1] = 32'h0000_0022;
`ifdef MISALIGN_SPLIT_EN
    issue(1'b0, 32'h03, 2'd1, 1'b0, 32'd0, 32'h0000_2211, 1'b0, 3, 1'b1);
    check_beat("lhu_b0", 1'b0, 4'b1000, 6'h00, 32'd0);
    @(negedge clk_i);
    check_beat("lhu_b1", 1'b0, 4'b0001, 6'h04, 32'd0);
`else
    issue(1'b0, 32'h03, 2'd1, 1'b0, 32'd0, 32'd0, 1'b1, 1, 1'b1);
    check_beat("lhu_err", 1'b0, 4'b0000, 6'h00, 32'd0);
`endif
    repeat (3) @(negedge clk_i);

    // 4: half store at top of window, wrapping second beat
`ifdef MISALIGN_SPLIT_EN
    issue(1'b1, 32'h3F, 2'd1, 1'b0, 32'h0000_BEEF, 32'd0, 1'b0, 3, 1'b1);
    check_beat("sh_b0", 1'b1, 4'b1000, 6'h3C, 32'hEF00_0000);
    @(negedge clk_i);
    check_beat("sh_b1", 1'b1, 4'b0001, 6'h00, 32'h0000_00BE);
`else
    issue(1'b1, 32'h3F, 2'd1, 1'b0, 32'h0000_BEEF, 32'd0, 1'b1, 1, 1'b1);
    check_beat("sh_err", 1'b0, 4'b0000, 6'h00, 32'd0);
`endif
    repeat (3) @(negedge clk_i);

    // 5: illegal size, then reset in the middle of an access
    issue(1'b1, 32'h08, 2'd3, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b1);
    check_beat("sz3", 1'b0, 4'b0000, 6'h00, 32'd0);
    repeat (3) @(negedge clk_i);
`ifdef MISALIGN_SPLIT_EN
    issue(1'b1, 32'h3F, 2'd1, 1'b0, 32'h0000_BEEF, 32'd0, 1'b0, 3, 1'b0);
    @(negedge clk_i);
    check("abort_pre_be", 32'(bus_be_o), 32'b0001);
`else
    issue(1'b1, 32'h04, 2'd2, 1'b0, 32'h1357_9BDF, 32'd0, 1'b0, 2, 1'b0);
    check("abort_pre_be", 32'(bus_be_o), 32'b1111);
`endif
    #2 rst_ni = 1'b0;
    #1;
    check_beat("abort", 1'b0, 4'b0000, 6'h00, 32'd0);
    check("abort_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("post_rst_ready", 32'(req_ready_o), 32'd1);
    repeat (4) @(negedge clk_i);

    // 6: valid held high across two aligned loads
    rd_tab[2] = 32'hCAFE_F00D;
    issue(1'b0, 32'h08, 2'd2, 1'b1, 32'd0, 32'hCAFE_F00D, 1'b0, 2, 1'b1);
    a1 = last_acc;
    check_beat("lw", 1'b0, 4'b1111, 6'h08, 32'd0);
    check("b2b_ready_beat", 32'(req_ready_o), 32'd0);
    issue(1'b0, 32'h0A, 2'd1, 1'b1, 32'd0, 32'hFFFF_CAFE, 1'b0, 2, 1'b1);
    check("b2b_spacing", 32'(last_acc - a1), 32'd3);
    check_beat("lh", 1'b0, 4'b1100, 6'h08, 32'd0);

    repeat (5) @(negedge clk_i);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
